decode_stage: RTL and testbench
===============================

DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, width of the extended immediate output (legal values 32 and 64).
REQ-002 SHALL have parameter DEPTH, default 2, number of decoded-instruction buffer entries (power of 2, at least 2).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, synchronous active-high reset.
REQ-005 SHALL have port flush, input, 1 bit, discards all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit, upstream instruction valid.
REQ-007 SHALL have port in_ready, output, 1 bit, stage can accept an instruction.
REQ-008 SHALL have port in_instr, input, 32 bits, raw MIPS instruction word.
REQ-009 SHALL have port in_pc, input, 32 bits, address of in_instr.
REQ-010 SHALL have port out_valid, output, 1 bit, head entry valid.
REQ-011 SHALL have port out_ready, input, 1 bit, downstream accepts the head entry.
REQ-012 SHALL have port out_pc, output, 32 bits, pc of the head entry.
REQ-013 SHALL have ports out_opcode (6 bits), out_rs, out_rt, out_rd and out_shamt (5 bits each), and out_funct (6 bits), all outputs carrying the raw fields of the head entry.
REQ-014 SHALL have port out_imm_ext, output, XLEN bits, extended immediate.
REQ-015 SHALL have port out_jtarget, output, 32 bits, jump target address.
REQ-016 SHALL have port out_type, output, 2 bits: 00 R-type, 01 I-type, 10 J-type, 11 illegal.

Function
REQ-017 SHALL decode fields as: opcode=[31:26], rs=[25:21], rt=[20:16], rd=[15:11], shamt=[10:6], funct=[5:0], imm=[15:0], adr=[25:0].
REQ-018 SHALL accept an instruction on any cycle where in_valid and in_ready are both 1 (a push).
REQ-019 SHALL decode at push time and store the decoded fields, not the raw word, in a FIFO of DEPTH entries.
REQ-020 SHALL drive in_ready = (count < DEPTH) from registered state only, with no combinational path from out_ready.
REQ-021 SHALL drive out_valid = (count != 0); all out_* data outputs SHALL reflect the FIFO head entry.
REQ-022 SHALL pop the head entry when out_valid and out_ready are both 1; payload SHALL be held stable while out_valid=1 and out_ready=0.
REQ-023 SHALL present an instruction pushed at cycle N on the outputs from cycle N+1 when the FIFO was empty (latency 1).
REQ-024 On a simultaneous push and pop, count SHALL remain unchanged and order SHALL be preserved.
REQ-025 Read and write pointers SHALL wrap modulo DEPTH.
REQ-026 out_type SHALL be decoded as follows:
- R-type (00): opcode 0x00.
- J-type (10): opcode 0x02 or 0x03.
- I-type (01): opcode 0x01, 0x04-0x0F, 0x20-0x26, 0x28, 0x29 or 0x2B.
- Illegal (11): any other opcode.
REQ-027 out_imm_ext SHALL be computed as follows:
- opcodes 0x0C, 0x0D, 0x0E (andi, ori, xori): zero-extend imm.
- opcode 0x0F (lui): imm<<16, sign-extended to XLEN.
- all other opcodes: sign-extend imm.
REQ-028 out_jtarget SHALL be {(pc+4)[31:28], adr, 2'b00}, with the addition wrapping modulo 2^32; it is computed for every entry regardless of type.
REQ-029 flush=1 SHALL set count and both pointers to 0 at the next edge; a push in that same cycle SHALL be discarded.
REQ-030 Illegal instructions SHALL be buffered and delivered like any other entry; no other output changes.

Reset
REQ-031 When rst=1 at a clock edge: count=0, pointers=0, out_valid=0, and in_ready=1 from the following cycle.
REQ-032 Data outputs while out_valid=0 are don't-care; rst SHALL take priority over flush, push and pop.
REQ-033 A reset asserted mid-stream SHALL discard all buffered entries.

Verification
REQ-034 SHALL test R-type decode: push 0x00221820 (add $3,$1,$2) with pc 0x00400000 -> next cycle out_valid=1, out_type=00, rs=1, rt=2, rd=3, funct=0x20.
REQ-035 SHALL test immediate extension: push addi 0x2001FFFF, then ori 0x3401FFFF, then lui 0x3C011234 -> out_imm_ext = 0xFFFFFFFF, then 0x0000FFFF, then 0x12340000 (XLEN=32).
REQ-036 SHALL test jump target: push 0x08000010 with pc 0x4000000C -> out_type=10, out_jtarget=0x40000040.
REQ-037 SHALL test backpressure: hold out_ready=0 and push DEPTH instructions -> in_ready=0; set out_ready=1 -> entries pop in push order and in_ready returns to 1 one cycle after the first pop.
REQ-038 SHALL test flush and reset: with 2 entries buffered, assert flush together with in_valid -> next cycle out_valid=0 and the concurrent push is lost; repeat using rst -> identical response.
REQ-039 SHALL test illegal opcode: push 0xFC000000 -> out_type=11, entry delivered in order.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage
//   MIPS instruction decode with a small output FIFO. Each accepted instruction
//   is decoded on entry, and the decoded fields are stored instead of the raw
//   word. The FIFO head drives all out_* data outputs.
//
//   Parameters
//     XLEN   width of the extended immediate (32 or 64)
//     DEPTH  FIFO entries (power of 2, >= 2)
//
//   Ports
//     clk, rst        clock, synchronous active-high reset
//     flush           discard every buffered entry (and any same-cycle push)
//     in_valid/ready  upstream handshake; in_ready depends on registered state only
//     in_instr/in_pc  raw instruction word and its address
//     out_valid/ready downstream handshake for the FIFO head
//     out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct
//                     raw fields of the head entry
//     out_imm_ext     zero/sign/lui-extended immediate
//     out_jtarget     {(pc+4)[31:28], adr, 2'b00}
//     out_type        00 R, 01 I, 10 J, 11 illegal
module decode_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [31:0]     in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_pc,
    output logic [5:0]      out_opcode,
    output logic [4:0]      out_rs,
    output logic [4:0]      out_rt,
    output logic [4:0]      out_rd,
    output logic [4:0]      out_shamt,
    output logic [5:0]      out_funct,
    output logic [XLEN-1:0] out_imm_ext,
    output logic [31:0]     out_jtarget,
    output logic [1:0]      out_type
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] TYPE_R   = 2'b00;
    localparam logic [1:0] TYPE_I   = 2'b01;
    localparam logic [1:0] TYPE_J   = 2'b10;
    localparam logic [1:0] TYPE_ILL = 2'b11;

    typedef struct packed {
        logic [31:0]     pc;
        logic [5:0]      opcode;
        logic [4:0]      rs;
        logic [4:0]      rt;
        logic [4:0]      rd;
        logic [4:0]      shamt;
        logic [5:0]      funct;
        logic [XLEN-1:0] imm_ext;
        logic [31:0]     jtarget;
        logic [1:0]      itype;
    } entry_t;

    function automatic logic [1:0] decode_type(input logic [5:0] op);
        logic [1:0] t;
        t = TYPE_ILL;
        case (op) inside
            6'h00:                                      t = TYPE_R;
            6'h02, 6'h03:                               t = TYPE_J;
            6'h01, [6'h04:6'h0F], [6'h20:6'h26],
            6'h28, 6'h29, 6'h2B:                        t = TYPE_I;
            default:                                    t = TYPE_ILL;
        endcase
        return t;
    endfunction

    function automatic logic [XLEN-1:0] extend_imm(input logic [5:0] op, input logic [15:0] imm);
        logic signed [15:0]     simm;
        logic signed [31:0]     lui;
        logic signed [XLEN-1:0] r;
        simm = imm;
        lui  = {imm, 16'h0000};
        case (op)
            6'h0C, 6'h0D, 6'h0E: begin
                r       = '0;
                r[15:0] = imm;
            end
            6'h0F:   r = lui;   // signed assignment widens with the sign of bit 31
            default: r = simm;
        endcase
        return r;
    endfunction

    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push;
    logic           pop;
    logic [3:0]     jt_hi_p0;
    entry_t         entry_p0;
    entry_t         head;
    entry_t         mem [DEPTH];

    // ---- stage p0: decode at the FIFO input ----
    // (pc+4)[31:28] only differs from pc[31:28] when the +4 carries out of
    // bit 27, i.e. when pc[27:2] is all ones.
    assign jt_hi_p0 = in_pc[31:28] + {3'b000, &in_pc[27:2]};

    always_comb begin
        entry_p0.pc      = in_pc;
        entry_p0.opcode  = in_instr[31:26];
        entry_p0.rs      = in_instr[25:21];
        entry_p0.rt      = in_instr[20:16];
        entry_p0.rd      = in_instr[15:11];
        entry_p0.shamt   = in_instr[10:6];
        entry_p0.funct   = in_instr[5:0];
        entry_p0.imm_ext = extend_imm(in_instr[31:26], in_instr[15:0]);
        entry_p0.jtarget = {jt_hi_p0, in_instr[25:0], 2'b00};
        entry_p0.itype   = decode_type(in_instr[31:26]);
    end

    assign in_ready  = (count < FULL_CNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready & ~flush;
    assign pop       = out_valid & out_ready;

    // ---- stage p1: FIFO storage (data only, no reset) ----
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= entry_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign head        = mem[rd_ptr];
    assign out_pc      = head.pc;
    assign out_opcode  = head.opcode;
    assign out_rs      = head.rs;
    assign out_rt      = head.rt;
    assign out_rd      = head.rd;
    assign out_shamt   = head.shamt;
    assign out_funct   = head.funct;
    assign out_imm_ext = head.imm_ext;
    assign out_jtarget = head.jtarget;
    assign out_type    = head.itype;

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [5:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  fn;
        logic [31:0] imm;
        logic [31:0] jt;
        logic [1:0]  ty;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [5:0]  out_opcode;
    logic [4:0]  out_rs;
    logic [4:0]  out_rt;
    logic [4:0]  out_rd;
    logic [4:0]  out_shamt;
    logic [5:0]  out_funct;
    logic [XLEN-1:0] out_imm_ext;
    logic [31:0] out_jtarget;
    logic [1:0]  out_type;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.XLEN(XLEN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm_ext(out_imm_ext),
        .out_jtarget(out_jtarget), .out_type(out_type)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    // Reference decode built directly from the field/type/extension rules.
    function automatic ent_t model(input logic [31:0] instr, input logic [31:0] pc);
        ent_t        e;
        int unsigned op;
        logic [15:0] imm;
        logic [31:0] pc4;
        op    = instr >> 26;
        imm   = instr[15:0];
        e.pc  = pc;
        e.op  = instr[31:26];
        e.rs  = instr[25:21];
        e.rt  = instr[20:16];
        e.rd  = instr[15:11];
        e.sh  = instr[10:6];
        e.fn  = instr[5:0];
        if (op == 0)                        e.ty = 2'b00;
        else if (op == 2 || op == 3)        e.ty = 2'b10;
        else if (op == 1 || (op >= 4 && op <= 15) || (op >= 32 && op <= 38) ||
                 op == 40 || op == 41 || op == 43) e.ty = 2'b01;
        else                                e.ty = 2'b11;
        if (op >= 12 && op <= 14)           e.imm = {16'h0000, imm};
        else if (op == 15)                  e.imm = {imm, 16'h0000};
        else                                e.imm = {{16{imm[15]}}, imm};
        pc4  = pc + 32'd4;
        e.jt = (pc4 & 32'hF000_0000) | {4'h0, instr[25:0], 2'b00};
        return e;
    endfunction

    function automatic ent_t obs();
        return {out_pc, out_opcode, out_rs, out_rt, out_rd, out_shamt, out_funct,
                out_imm_ext, out_jtarget, out_type};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_one(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_rtype();
        out_ready = 1'b0;
        push_one(32'h00221820, 32'h00400000);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rtype_valid: got %b want 1", out_valid); end
        n_checks++;
        if ({out_type, out_rs, out_rt, out_rd, out_funct} !== {2'b00, 5'd1, 5'd2, 5'd3, 6'h20}) begin
            n_fail++;
            $display("FAIL rtype_fields: got type=%b rs=%0d rt=%0d rd=%0d funct=%h want 00 1 2 3 20",
                     out_type, out_rs, out_rt, out_rd, out_funct);
        end
        n_checks++;
        if (obs() !== model(32'h00221820, 32'h00400000)) begin
            n_fail++; $display("FAIL rtype_entry: got %h want %h", obs(), model(32'h00221820, 32'h00400000));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rtype_pop: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_imm();
        logic [31:0] ins [3] = '{32'h2001FFFF, 32'h3401FFFF, 32'h3C011234};
        logic [31:0] exp [3] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'h12340000};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(ins[i], 32'h100 + 32'(i * 4));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_imm_ext !== exp[i]) begin
                n_fail++;
                $display("FAIL imm_ext_%0d: got valid=%b imm=%h want valid=1 imm=%h", i, out_valid, out_imm_ext, exp[i]);
            end
            tick();
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL imm_drain: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_jump();
        out_ready = 1'b0;
        push_one(32'h08000010, 32'h4000000C);
        n_checks++;
        if (out_type !== 2'b10 || out_jtarget !== 32'h40000040) begin
            n_fail++;
            $display("FAIL jump: got type=%b jtarget=%h want 10 40000040", out_type, out_jtarget);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        ent_t exp [DEPTH];
        logic [31:0] ins;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            ins = $urandom();
            exp[i] = model(ins, 32'h2000 + 32'(i * 4));
            push_one(ins, 32'h2000 + 32'(i * 4));
        end
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_full: got in_ready %b want 0", in_ready); end
        // Push attempt while full must be ignored.
        push_one(32'h00000000, 32'hDEAD0000);
        out_ready = 1'b1;
        n_checks++;
        if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_comb_ready: got in_ready %b want 0", in_ready); end
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs() !== exp[i]) begin
                n_fail++; $display("FAIL bp_order_%0d: got valid=%b %h want %h", i, out_valid, obs(), exp[i]);
            end
            tick();
            if (i == 0) begin
                n_checks++;
                if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_return: got %b want 1", in_ready); end
            end
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got out_valid %b want 0", out_valid); end
    endtask

    task automatic test_flush_reset(input bit use_rst);
        string nm;
        nm = use_rst ? "rst" : "flush";
        out_ready = 1'b0;
        push_one(32'h20010001, 32'h3000);
        push_one(32'h20020002, 32'h3004);
        n_checks++;
        if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s_prefill: got out_valid %b want 1", nm, out_valid); end
        in_valid = 1'b1; in_instr = 32'h20030003; in_pc = 32'h3008;
        if (use_rst) rst = 1'b1; else flush = 1'b1;
        tick();
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL %s_clear: got valid=%b ready=%b want 0 1", nm, out_valid, in_ready);
        end
        tick();
        n_checks++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_push_lost: got out_valid %b want 0", nm, out_valid); end
    endtask

    task automatic test_illegal();
        logic [31:0] ins [3] = '{32'h8C220010, 32'hFC000000, 32'h00221822};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_one(ins[i], 32'h5000 + 32'(i * 4));
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || obs() !== model(ins[i], 32'h5000 + 32'(i * 4))) begin
                n_fail++; $display("FAIL illegal_order_%0d: got %h want %h", i, obs(), model(ins[i], 32'h5000 + 32'(i * 4)));
            end
            if (i == 1) begin
                n_checks++;
                if (out_type !== 2'b11) begin n_fail++; $display("FAIL illegal_type: got %b want 11", out_type); end
            end
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        ent_t q[$];
        logic [31:0] r;
        logic [31:0] pc;
        bit do_push, do_pop, do_flush;
        int errs = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            n_checks++;
            if (out_valid !== (q.size() != 0) || in_ready !== (q.size() < DEPTH)) begin
                n_fail++; errs++;
                if (errs < 20) $display("FAIL rand_hs cyc %0d: got valid=%b ready=%b want %b %b",
                                        cyc, out_valid, in_ready, q.size() != 0, q.size() < DEPTH);
            end
            if (q.size() != 0) begin
                n_checks++;
                if (obs() !== q[0]) begin
                    n_fail++; errs++;
                    if (errs < 20) $display("FAIL rand_head cyc %0d: got %h want %h", cyc, obs(), q[0]);
                end
            end
            r  = $urandom();
            pc = $urandom();
            if ($urandom_range(0, 3) == 0) pc = pc | 32'h0FFF_FFFC;
            in_instr  = {6'($urandom_range(0, 63)), r[25:0]};
            in_pc     = pc;
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 63) == 0);
            do_flush  = flush;
            do_push   = in_valid && (q.size() < DEPTH) && !flush;
            do_pop    = (q.size() != 0) && out_ready;
            tick();
            if (do_flush) q.delete();
            else begin
                if (do_pop) void'(q.pop_front());
                if (do_push) q.push_back(model(in_instr, in_pc));
            end
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_imm();
        test_jump();
        test_backpressure();
        test_flush_reset(1'b0);
        test_flush_reset(1'b1);
        test_illegal();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
